// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// One full-subtractor cell feeds a borrow flop; operands shift right while
// the difference bits enter the result register at the MSB end.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} st_t;

  st_t            st, st_nx;
  logic [WIDTH-1:0] ra, rb, res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bnx, last;

`ifdef SERIAL_SUB_OVF_EN
  // operand MSBs are lost to the shift, so keep a copy for the overflow flag
  logic am, bm;
`endif

  // full-subtractor cell on the current LSBs plus the stored borrow
  always_comb begin
    d    = ra[0] ^ rb[0] ^ br;
    bnx  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    last = (cnt == CW'(WIDTH - 1));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // next-state logic; start outside IDLE is dropped, not queued
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (start) st_nx = SHIFT;
      SHIFT:   if (last)  st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign busy = (st == SHIFT);
  assign done = (st == DONE);

  // datapath: capture on accept, shift in SHIFT, publish result on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am   <= 1'b0;
      bm   <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            am  <= a[WIDTH-1];
            bm  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          res <= {d, res[WIDTH-1:1]};
          br  <= bnx;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= {d, res[WIDTH-1:1]};
            bout <= bnx;
`ifdef SERIAL_SUB_OVF_EN
            // final d is the result MSB
            ovf  <= (am ^ bm) & (am ^ d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
